// File: rtl/float_pkg.sv
// -----------------------------------------------------------------------------
// float_pkg
// Shared constants and helper functions for the integer-to-float conversion
// path and the float arithmetic units it feeds.
//   exp_bias(e)        : exponent bias 2^(e-1)-1
//   float_size(e, m)   : packed float width 1+e+m
//   sign_pos(e, m)     : bit index of the sign in a packed float
//   exp_lsb(m)         : bit index of the exponent LSB in a packed float
//   exp_all_ones(e)    : exponent code used for infinity
// Fixed localparams describe the default single-precision format.
// -----------------------------------------------------------------------------
package float_pkg;

    localparam int EXPONENT_SIZE_DEF = 8;
    localparam int MANTISSA_SIZE_DEF = 23;

    function automatic int exp_bias(input int exp_size);
        return (1 << (exp_size - 1)) - 1;
    endfunction

    function automatic int float_size(input int exp_size, input int man_size);
        return 1 + exp_size + man_size;
    endfunction

    function automatic int sign_pos(input int exp_size, input int man_size);
        return exp_size + man_size;
    endfunction

    function automatic int exp_lsb(input int man_size);
        return man_size;
    endfunction

    function automatic int exp_all_ones(input int exp_size);
        return (1 << exp_size) - 1;
    endfunction

    localparam int FLOAT_SIZE = float_size(EXPONENT_SIZE_DEF, MANTISSA_SIZE_DEF);
    localparam int SIGN_POS   = sign_pos(EXPONENT_SIZE_DEF, MANTISSA_SIZE_DEF);
    localparam int EXP_LSB    = exp_lsb(MANTISSA_SIZE_DEF);
    localparam logic [EXPONENT_SIZE_DEF-1:0] EXP_ALL_ONES = {EXPONENT_SIZE_DEF{1'b1}};

endpackage

// File: rtl/leading_one_pos.sv
// -----------------------------------------------------------------------------
// leading_one_pos
// Combinational priority encoder: returns the index of the highest set bit.
// The result is meaningless for an all-zero input; callers mask that case.
// Ports:
//   vec : input vector, WIDTH bits
//   pos : index of the most significant set bit, clog2(WIDTH) bits
// -----------------------------------------------------------------------------
module leading_one_pos #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]         vec,
    output logic [$clog2(WIDTH)-1:0] pos
);

    localparam int POS_W = $clog2(WIDTH);

    // Scan upward so the last set bit seen (the highest) wins
    always_comb begin
        pos = {POS_W{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            pos = vec[i] ? POS_W'(i) : pos;
        end
    end

endmodule

// File: rtl/int_to_float.sv
// -----------------------------------------------------------------------------
// int_to_float
// Three-stage pipelined conversion of a two's-complement integer into a packed
// IEEE-754-style float {sign, exponent, fraction}.
//   Stage 1 : sign, magnitude, zero flag
//   Stage 2 : leading-one search, normalising left shift, biased exponent
//   Stage 3 : fraction extraction, rounding, overflow saturation, packing
// Build option:
//   INT_TO_FLOAT_ROUND_NEAREST_EN defined   -> round to nearest, ties to even
//   INT_TO_FLOAT_ROUND_NEAREST_EN undefined -> truncate toward zero
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   s_valid/s_ready   : input handshake, s_data = signed integer
//   m_valid/m_ready   : output handshake, m_data = packed float
// The whole pipeline advances together; any output stall holds every stage.
// -----------------------------------------------------------------------------
module int_to_float
    import float_pkg::*;
#(
    parameter int INT_SIZE      = 32,
    parameter int EXPONENT_SIZE = EXPONENT_SIZE_DEF,
    parameter int MANTISSA_SIZE = MANTISSA_SIZE_DEF
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [INT_SIZE-1:0]                  s_data,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [EXPONENT_SIZE+MANTISSA_SIZE:0] m_data
);

    localparam int FLOAT_W = float_size(EXPONENT_SIZE, MANTISSA_SIZE);
    localparam int SIGN_P  = sign_pos(EXPONENT_SIZE, MANTISSA_SIZE);
    localparam int EXP_L   = exp_lsb(MANTISSA_SIZE);
    localparam int POS_W   = $clog2(INT_SIZE);
    // Exponent arithmetic is wide enough for both the field and any bit index,
    // so saturation on narrow exponent formats cannot wrap.
    localparam int XW      = (EXPONENT_SIZE + 1 > POS_W + 1) ? EXPONENT_SIZE + 1 : POS_W + 1;
    // Bits below the hidden one, padded so fraction/guard/sticky always exist
    localparam int EXT_W   = INT_SIZE + MANTISSA_SIZE + 1;
    localparam logic [XW-1:0] BIAS_X    = XW'(exp_bias(EXPONENT_SIZE));
    localparam logic [XW-1:0] EXP_MAX_X = XW'(exp_all_ones(EXPONENT_SIZE));

    logic                  en_s;

    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_sign_q,  s1_sign_d;
    logic                  s1_zero_q,  s1_zero_d;
    logic [INT_SIZE-1:0]   s1_mag_q,   s1_mag_d;

    logic [POS_W-1:0]      lop_pos_s;
    logic [POS_W-1:0]      shift_s;

    logic                  s2_valid_q, s2_valid_d;
    logic                  s2_sign_q,  s2_sign_d;
    logic                  s2_zero_q,  s2_zero_d;
    logic [INT_SIZE-1:0]   s2_norm_q,  s2_norm_d;
    logic [XW-1:0]         s2_exp_q,   s2_exp_d;

    logic [EXT_W-1:0]      ext_s;
    logic [MANTISSA_SIZE-1:0] frac_s;
    logic [MANTISSA_SIZE-1:0] frac_rnd_s;
    logic [XW-1:0]         exp_rnd_s;
    logic [FLOAT_W-1:0]    packed_s;
    logic                  unused_bits_s;

`ifdef INT_TO_FLOAT_ROUND_NEAREST_EN
    logic                  guard_s;
    logic                  sticky_s;
    logic                  round_up_s;
    logic                  carry_s;
`endif

    logic                  m_valid_q, m_valid_d;
    logic [FLOAT_W-1:0]    m_data_q,  m_data_d;

    // Global advance: move whenever the output slot is empty or being drained
    always_comb begin
        en_s = !m_valid_q || m_ready;
    end

    assign s_ready = en_s;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;

    // Stage 1: sign, magnitude and zero flag of the accepted word
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_zero_d  = s1_zero_q;
        s1_mag_d   = s1_mag_q;
        if (en_s) begin
            s1_valid_d = s_valid;
            if (s_valid) begin
                s1_sign_d = s_data[INT_SIZE-1];
                s1_zero_d = (s_data == {INT_SIZE{1'b0}});
                // Most negative input negates to itself, which is exactly
                // 2^(INT_SIZE-1) when read as unsigned.
                s1_mag_d  = s_data[INT_SIZE-1] ? (~s_data + INT_SIZE'(1)) : s_data;
            end else begin
                s1_mag_d  = s1_mag_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    leading_one_pos #(
        .WIDTH (INT_SIZE)
    ) u_lop (
        .vec (s1_mag_q),
        .pos (lop_pos_s)
    );

    // Stage 2: normalise so the leading one lands on the MSB, bias the exponent
    always_comb begin
        shift_s    = POS_W'(INT_SIZE - 1) - lop_pos_s;
        s2_valid_d = s2_valid_q;
        s2_sign_d  = s2_sign_q;
        s2_zero_d  = s2_zero_q;
        s2_norm_d  = s2_norm_q;
        s2_exp_d   = s2_exp_q;
        if (en_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_sign_d = s1_sign_q;
                s2_zero_d = s1_zero_q;
                s2_norm_d = s1_mag_q << shift_s;
                s2_exp_d  = XW'(lop_pos_s) + BIAS_X;
            end else begin
                s2_norm_d = s2_norm_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Stage 3 datapath: extract fraction, round, saturate, pack
    always_comb begin
        ext_s  = {s2_norm_q[INT_SIZE-2:0], {(MANTISSA_SIZE + 2){1'b0}}};
        frac_s = ext_s[EXT_W-1 -: MANTISSA_SIZE];
`ifdef INT_TO_FLOAT_ROUND_NEAREST_EN
        guard_s    = ext_s[EXT_W-1-MANTISSA_SIZE];
        sticky_s   = |ext_s[EXT_W-2-MANTISSA_SIZE:0];
        round_up_s = guard_s && (sticky_s || frac_s[0]);
        {carry_s, frac_rnd_s} = {1'b0, frac_s} + {{MANTISSA_SIZE{1'b0}}, round_up_s};
        if (carry_s) begin
            // All-ones fraction rolled over: mantissa becomes 1.0 of next binade
            frac_rnd_s = {MANTISSA_SIZE{1'b0}};
            exp_rnd_s  = s2_exp_q + XW'(1);
        end else begin
            exp_rnd_s  = s2_exp_q;
        end
`else
        frac_rnd_s = frac_s;
        exp_rnd_s  = s2_exp_q;
`endif
        packed_s = {FLOAT_W{1'b0}};
        if (s2_zero_q) begin
            packed_s = {FLOAT_W{1'b0}};
        end else if (exp_rnd_s >= EXP_MAX_X) begin
            packed_s[SIGN_P]            = s2_sign_q;
            packed_s[SIGN_P-1:EXP_L]    = {EXPONENT_SIZE{1'b1}};
            packed_s[EXP_L-1:0]         = {MANTISSA_SIZE{1'b0}};
        end else begin
            packed_s[SIGN_P]            = s2_sign_q;
            packed_s[SIGN_P-1:EXP_L]    = exp_rnd_s[EXPONENT_SIZE-1:0];
            packed_s[EXP_L-1:0]         = frac_rnd_s;
        end
    end

    // The hidden one (and, when truncating, the discarded low bits) never
    // reach the output.
`ifdef INT_TO_FLOAT_ROUND_NEAREST_EN
    assign unused_bits_s = s2_norm_q[INT_SIZE-1];
`else
    assign unused_bits_s = ^{s2_norm_q[INT_SIZE-1], ext_s[EXT_W-1-MANTISSA_SIZE:0]};
`endif

    // Stage 3 register control: output only updates on a real word
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        if (en_s) begin
            m_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                m_data_d = packed_s;
            end else begin
                m_data_d = m_data_q;
            end
        end else begin
            m_valid_d = m_valid_q;
        end
    end

    // Pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_mag_q   <= {INT_SIZE{1'b0}};
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_norm_q  <= {INT_SIZE{1'b0}};
            s2_exp_q   <= {XW{1'b0}};
            m_valid_q  <= 1'b0;
            m_data_q   <= {FLOAT_W{1'b0}};
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_zero_q  <= s1_zero_d;
            s1_mag_q   <= s1_mag_d;
            s2_valid_q <= s2_valid_d;
            s2_sign_q  <= s2_sign_d;
            s2_zero_q  <= s2_zero_d;
            s2_norm_q  <= s2_norm_d;
            s2_exp_q   <= s2_exp_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
        end
    end

endmodule

// File: tb/tb_int_to_float.sv
// -----------------------------------------------------------------------------
// tb_int_to_float
// Directed self-checking bench for int_to_float with default parameters
// (32-bit integer to single precision). Expected values for rounding-sensitive
// inputs follow INT_TO_FLOAT_ROUND_NEAREST_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_int_to_float;
    import float_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  s_valid;
    logic                  s_ready;
    logic [31:0]           s_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [FLOAT_SIZE-1:0] m_data;

    int checks = 0;
    int errors = 0;

    int_to_float #(
        .INT_SIZE      (32),
        .EXPONENT_SIZE (8),
        .MANTISSA_SIZE (23)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data)
    );

    always #5 clk = ~clk;

    // Independent reference: convert via double precision, then narrow.
    function automatic logic [31:0] ref_conv(input logic [31:0] x);
        real         r;
        logic [63:0] d;
        int          ei;
        logic [22:0] f;
        logic        g;
        logic        st;
        if (x == 32'd0) return 32'd0;
        r  = $itor($signed(x));
        d  = $realtobits(r);
        ei = int'(d[62:52]) - 896;
        f  = d[51:29];
        g  = d[28];
        st = |d[27:0];
`ifdef INT_TO_FLOAT_ROUND_NEAREST_EN
        if (g && (st || f[0])) begin
            if (f == 23'h7FFFFF) begin
                f  = 23'd0;
                ei = ei + 1;
            end else begin
                f = f + 23'd1;
            end
        end
`else
        if (g && st) f = f;
`endif
        return {d[63], 8'(ei), f};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; s_valid = 1'b0; s_data = 32'd0; m_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b exp 0", m_valid); end
        checks++;
        if (m_data !== 32'd0) begin errors++; $display("FAIL reset_m_data got %h exp 00000000", m_data); end
        reset = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b exp 1", s_ready); end
    endtask

    task automatic test_latency();
        logic [31:0] vin [3];
        logic [31:0] vexp[3];
        int lat;
        vin[0] = 32'd1;          vexp[0] = 32'h3F800000;
        vin[1] = 32'hFFFFFFFF;   vexp[1] = 32'hBF800000;
        vin[2] = 32'd0;          vexp[2] = 32'h00000000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            s_data = vin[k]; s_valid = 1'b1; m_ready = 1'b1;
            #1;
            checks++;
            if (s_ready !== 1'b1) begin errors++; $display("FAIL lat_s_ready got %b exp 1", s_ready); end
            @(negedge clk);
            s_valid = 1'b0;
            lat = 1;
            while (m_valid !== 1'b1 && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            checks++;
            if (lat !== 3) begin errors++; $display("FAIL lat_cycles[%0d] got %0d exp 3", k, lat); end
            checks++;
            if (m_data !== vexp[k]) begin errors++; $display("FAIL lat_data[%0d] got %h exp %h", k, m_data, vexp[k]); end
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b0) begin errors++; $display("FAIL lat_single[%0d] got %b exp 0", k, m_valid); end
        end
    endtask

    task automatic test_boundary();
        logic [31:0] vin [8];
        logic [31:0] vexp[8];
        int oi = 0;
        vin[0] = 32'h80000000; vexp[0] = 32'hCF000000;
        vin[1] = 32'd16777217; vexp[1] = 32'h4B800000;
`ifdef INT_TO_FLOAT_ROUND_NEAREST_EN
        vin[2] = 32'd16777219; vexp[2] = 32'h4B800002;
        vin[3] = 32'h7FFFFFFF; vexp[3] = 32'h4F000000;
`else
        vin[2] = 32'd16777219; vexp[2] = 32'h4B800001;
        vin[3] = 32'h7FFFFFFF; vexp[3] = 32'h4EFFFFFF;
`endif
        vin[4] = 32'd10;       vexp[4] = 32'h41200000;
        vin[5] = 32'hFFFFFFF6; vexp[5] = 32'hC1200000;
        vin[6] = 32'd255;      vexp[6] = 32'h437F0000;
        vin[7] = 32'd65536;    vexp[7] = 32'h47800000;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            m_ready = 1'b1;
            s_valid = (c < 8);
            s_data  = (c < 8) ? vin[c] : 32'd0;
            #1;
            if (m_valid === 1'b1) begin
                checks++;
                if (oi >= 8) begin
                    errors++; $display("FAIL bnd_extra got %h exp none", m_data);
                end else if (m_data !== vexp[oi]) begin
                    errors++; $display("FAIL bnd_data[%0d] got %h exp %h", oi, m_data, vexp[oi]);
                end
                oi++;
            end
        end
        s_valid = 1'b0;
        checks++;
        if (oi !== 8) begin errors++; $display("FAIL bnd_count got %0d exp 8", oi); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vexp[8];
        int          in_i   = 0;
        int          out_i  = 0;
        logic        held_v = 1'b0;
        logic [31:0] held_d = 32'd0;
        vexp[0] = 32'h3F800000; vexp[1] = 32'h40000000;
        vexp[2] = 32'h40400000; vexp[3] = 32'h40800000;
        vexp[4] = 32'h40A00000; vexp[5] = 32'h40C00000;
        vexp[6] = 32'h40E00000; vexp[7] = 32'h41000000;
        for (int cyc = 0; cyc < 40 && out_i < 8; cyc++) begin
            @(negedge clk);
            m_ready = !(cyc >= 4 && cyc < 9);
            s_valid = (in_i < 8);
            s_data  = 32'(in_i + 1);
            #1;
            if (held_v) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== held_d) begin
                    errors++; $display("FAIL b2b_hold got %b/%h exp 1/%h", m_valid, m_data, held_d);
                end
            end
            if (m_valid === 1'b1 && !m_ready) begin
                checks++;
                if (s_ready !== 1'b0) begin errors++; $display("FAIL b2b_s_ready got %b exp 0", s_ready); end
            end
            if (m_valid === 1'b1 && m_ready) begin
                checks++;
                if (m_data !== vexp[out_i]) begin
                    errors++; $display("FAIL b2b_data[%0d] got %h exp %h", out_i, m_data, vexp[out_i]);
                end
                out_i++;
            end
            held_v = (m_valid === 1'b1) && !m_ready;
            held_d = m_data;
            if (s_valid && s_ready) in_i++;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        checks++;
        if (out_i !== 8 || in_i !== 8) begin
            errors++; $display("FAIL b2b_count got in %0d out %0d exp 8 8", in_i, out_i);
        end
        @(negedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL b2b_dup got %b exp 0", m_valid); end
    endtask

    task automatic test_reset_midstream();
        int lat;
        @(negedge clk);
        m_ready = 1'b1; s_valid = 1'b1; s_data = 32'd5;
        @(negedge clk);
        s_data = 32'd6;
        @(negedge clk);
        s_data = 32'd7; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; s_valid = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b exp 0", m_valid); end
        checks++;
        if (m_data !== 32'd0) begin errors++; $display("FAIL rst_mid_data got %h exp 00000000", m_data); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_flush[%0d] got %b exp 0", c, m_valid); end
        end
        @(negedge clk);
        s_valid = 1'b1; s_data = 32'd100;
        @(negedge clk);
        s_valid = 1'b0;
        lat = 1;
        while (m_valid !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL rst_mid_lat got %0d exp 3", lat); end
        checks++;
        if (m_data !== 32'h42C80000) begin errors++; $display("FAIL rst_mid_next got %h exp 42c80000", m_data); end
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] exp_v;
        logic [31:0] r;
        int sent = 0;
        int cyc  = 0;
        localparam int N = 10000;
        while ((sent < N || q.size() > 0) && cyc < 60000) begin
            @(negedge clk);
            s_valid = (sent < N) && ($urandom_range(0, 3) != 0);
            r = $urandom();
            case ($urandom_range(0, 3))
                0:       s_data = r >> $urandom_range(0, 31);
                1:       s_data = -(r >> $urandom_range(0, 31));
                default: s_data = r;
            endcase
            m_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (m_valid === 1'b1 && m_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rnd_spurious got %h exp none", m_data);
                end else begin
                    exp_v = q.pop_front();
                    if (m_data !== exp_v) begin
                        errors++; $display("FAIL rnd_data got %h exp %h", m_data, exp_v);
                    end
                end
            end
            if (s_valid && s_ready) begin
                q.push_back(ref_conv(s_data));
                sent++;
            end
            cyc++;
        end
        s_valid = 1'b0;
        checks++;
        if (sent !== N || q.size() !== 0) begin
            errors++; $display("FAIL rnd_timeout got sent %0d pending %0d exp %0d 0", sent, q.size(), N);
        end
    endtask

    initial begin
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = 32'd0;
        m_ready = 1'b0;
        test_reset();
        test_latency();
        test_boundary();
        test_back_to_back();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
